quad_decoder_mc: RTL and testbench
==================================

QUAD_DECODER_MC -- requirements
Module: quad_decoder_mc

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent encoder channels (1..8).
REQ-002 Parameter CNT_W, default 16, position counter width in bits (8..32).
REQ-003 Parameter FILT_LEN, default 4, consecutive stable cycles needed to accept a new input level (1..15).
REQ-004 Parameter SYNC_STAGES, default 2, input synchroniser depth (2..3).
REQ-005 clk  in  1  clock; all logic on its rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 enc_a  in  NUM_CH  channel A pins, asynchronous.
REQ-008 enc_b  in  NUM_CH  channel B pins, asynchronous.
REQ-009 cnt_clr  in  NUM_CH  per-channel single-cycle counter clear.
REQ-010 snap  in  1  single-cycle snapshot strobe, all channels.
REQ-011 err_clr  in  NUM_CH  per-channel clear of sticky error.
REQ-012 count_o  out  NUM_CH*CNT_W  live signed position; channel i at bits [i*CNT_W +: CNT_W].
REQ-013 snap_o  out  NUM_CH*CNT_W  snapshot positions, same packing.
REQ-014 dir_o  out  NUM_CH  last direction; 0 = forward (A leads), 1 = reverse.
REQ-015 step_o  out  NUM_CH  one-cycle pulse per accepted legal transition.
REQ-016 err_o  out  NUM_CH  sticky illegal-transition flag.

Function
REQ-017 Each pin passes through SYNC_STAGES flops, then a filter: filtered level changes only after the synchronised level has differed from it for FILT_LEN consecutive cycles; any bounce restarts the filter's count.
REQ-018 State S = {B_filt, A_filt}; forward sequence 0->1->3->2->0 adds +1 to count and sets dir_o=0; reverse sequence 0->2->3->1->0 adds -1 and sets dir_o=1.
REQ-019 Two-bit change (0<->3, 1<->2) is illegal: count and dir_o unchanged, step_o low, err_o set.
REQ-020 Count wraps modulo 2^CNT_W, two's complement: max positive +1 -> min negative; 0 -1 -> all ones.
REQ-021 count_o, dir_o, step_o and err_o update in the cycle after S changes; latency from pin edge to count_o change is SYNC_STAGES+FILT_LEN+1 cycles.
REQ-022 cnt_clr[i] sets count i to 0 next cycle and takes priority over a same-cycle transition; that step is lost, dir_o and step_o still update.
REQ-023 snap loads every channel's current count_o value (pre-update) into snap_o in one edge; snap_o holds until the next snap.
REQ-024 err_clr[i] clears err_o[i]; a same-cycle illegal transition wins (err_o stays 1).
REQ-025 Channels are fully independent; simultaneous events on different channels are all processed in the same cycle.

Reset
REQ-026 While reset is high: count_o=0, snap_o=0, dir_o=0, step_o=0, err_o=0, synchroniser and filter flops=0, filter counters=0, per-channel valid flag=0.
REQ-027 First filtered state accepted after reset sets valid only: no count, step or error.
REQ-028 Reset asserted mid-operation overrides all other inputs within the same edge.

Structure
REQ-029 Shared package quad_pkg holds DIR_FWD/DIR_REV, state encodings S00..S11, and the transition-class encoding (NONE, INC, DEC, ILLEGAL) with its decode function.
REQ-030 One sub-module quad_chan (sync, filter, decode, counter, error) is instantiated NUM_CH times via generate; quad_decoder_mc adds snapshot registers and packing only.

Verification
REQ-031 NUM_CH=2, FILT_LEN=4: 8 forward quadrature cycles on ch0 (16-clock phases) -> count_o[0]=32, dir_o[0]=0, 32 step_o pulses; ch1 stays 0.
REQ-032 ch1 reverse from 0 for 3 transitions -> count 0xFFFD, dir_o[1]=1; first count change is 7 cycles after the first pin edge.
REQ-033 A pulse of 3 cycles on enc_a -> no state change; 4 stable cycles -> exactly one count.
REQ-034 S jumps 0->3 -> err_o=1, count unchanged; err_clr -> 0; err_clr with a concurrent illegal jump -> remains 1.
REQ-035 Count 0x7FFF plus a forward step -> 0x8000; cnt_clr together with a step -> 0; snap on the same edge -> snap_o holds the pre-clear value.
REQ-036 Reset with pins held at 11, then release -> no err, no step, count 0.

Source files
------------

// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// Module : quad_pkg
// Brief  : Shared quadrature constants, state codes and transition classifier.
// Rev    : 1.0  initial release
// ============================================================================
package quad_pkg;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Quadrature state S = {B, A}
    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;

    typedef enum logic [1:0] {
        TR_NONE    = 2'd0,
        TR_INC     = 2'd1,
        TR_DEC     = 2'd2,
        TR_ILLEGAL = 2'd3
    } trans_t;

    function automatic trans_t quad_classify(input logic [1:0] prev, input logic [1:0] cur);
        trans_t t;
        t = TR_ILLEGAL;
        if (prev == cur) begin
            t = TR_NONE;
        end else begin
            case ({prev, cur})
                {S00, S01}, {S01, S11}, {S11, S10}, {S10, S00}: t = TR_INC;
                {S00, S10}, {S10, S11}, {S11, S01}, {S01, S00}: t = TR_DEC;
                default:                                        t = TR_ILLEGAL;
            endcase
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_chan.sv
`default_nettype none
// ============================================================================
// Module : quad_chan
// Brief  : One encoder channel: synchroniser, glitch filter, decode, counter.
// Rev    : 1.0  initial release
// ============================================================================
module quad_chan
    import quad_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int FILT_LEN    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enc_a,
    input  logic             i_enc_b,
    input  logic             i_cnt_clr,
    input  logic             i_err_clr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_dir,
    output logic             o_step,
    output logic             o_err
);

    localparam logic [3:0] c_FILT_LAST   = 4'(FILT_LEN - 1);
    localparam logic [4:0] c_SETTLE_LAST = 5'(SYNC_STAGES + FILT_LEN - 1);

    logic [1:0] w_pin;
    logic [1:0] w_filt;
    logic [1:0] w_stable;

    assign w_pin = {i_enc_b, i_enc_a};

    for (genvar g = 0; g < 2; g++) begin : g_pin
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_filt;
        logic [3:0]             r_fcnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync <= '0;
                r_filt <= 1'b0;
                r_fcnt <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin[g]};
                if (r_sync[SYNC_STAGES-1] == r_filt) begin
                    r_fcnt <= '0;
                end else if (r_fcnt == c_FILT_LAST) begin
                    r_filt <= r_sync[SYNC_STAGES-1];
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 4'd1;
                end
            end
        end

        assign w_filt[g]   = r_filt;
        assign w_stable[g] = (r_sync[SYNC_STAGES-1] == r_filt);
    end

    logic [1:0]       r_prev;
    logic             r_valid;
    logic [4:0]       r_settle;
    logic [CNT_W-1:0] r_count;
    logic             r_dir;
    logic             r_step;
    logic             r_err;
    trans_t           w_trans;
    logic             w_inc;
    logic             w_dec;
    logic             w_ill;

    assign w_trans = quad_classify(r_prev, w_filt);
    assign w_inc   = r_valid && (w_trans == TR_INC);
    assign w_dec   = r_valid && (w_trans == TR_DEC);
    assign w_ill   = r_valid && (w_trans == TR_ILLEGAL);

    // Until the pipeline has flushed and the filter is settled, the filtered
    // level is only tracked, so the first level seen after reset never counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev   <= S00;
            r_valid  <= 1'b0;
            r_settle <= '0;
            r_count  <= '0;
            r_dir    <= DIR_FWD;
            r_step   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_prev <= w_filt;
            if (!r_valid) begin
                if (&w_stable) begin
                    if (r_settle == c_SETTLE_LAST) begin
                        r_valid <= 1'b1;
                    end
                    r_settle <= r_settle + 5'd1;
                end else begin
                    r_settle <= '0;
                end
            end

            r_step <= w_inc | w_dec;

            if (w_inc) begin
                r_dir <= DIR_FWD;
            end else if (w_dec) begin
                r_dir <= DIR_REV;
            end

            if (i_cnt_clr) begin
                r_count <= '0;
            end else if (w_inc) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_dec) begin
                r_count <= r_count - CNT_W'(1);
            end

            if (w_ill) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_count = r_count;
    assign o_dir   = r_dir;
    assign o_step  = r_step;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/quad_decoder_mc.sv
`default_nettype none
// ============================================================================
// Module : quad_decoder_mc
// Brief  : Multi-channel quadrature decoder with shared snapshot strobe.
// Rev    : 1.0  initial release
// ============================================================================
module quad_decoder_mc
    import quad_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int FILT_LEN    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    input  logic [NUM_CH-1:0]       cnt_clr,
    input  logic                    snap,
    input  logic [NUM_CH-1:0]       err_clr,
    output logic [NUM_CH*CNT_W-1:0] count_o,
    output logic [NUM_CH*CNT_W-1:0] snap_o,
    output logic [NUM_CH-1:0]       dir_o,
    output logic [NUM_CH-1:0]       step_o,
    output logic [NUM_CH-1:0]       err_o
);

    logic [NUM_CH*CNT_W-1:0] w_count;
    logic [NUM_CH*CNT_W-1:0] r_snap;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        quad_chan #(
            .CNT_W       (CNT_W),
            .FILT_LEN    (FILT_LEN),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .i_enc_a   (enc_a[gi]),
            .i_enc_b   (enc_b[gi]),
            .i_cnt_clr (cnt_clr[gi]),
            .i_err_clr (err_clr[gi]),
            .o_count   (w_count[gi*CNT_W +: CNT_W]),
            .o_dir     (dir_o[gi]),
            .o_step    (step_o[gi]),
            .o_err     (err_o[gi])
        );
    end

    // Snapshot captures the registered counts, i.e. the value before this edge's update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap <= '0;
        end else if (snap) begin
            r_snap <= w_count;
        end
    end

    assign count_o = w_count;
    assign snap_o  = r_snap;

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder_mc.sv
`default_nettype none
// ============================================================================
// Module : tb_quad_decoder_mc
// Brief  : Self-checking bench: vector table, corner sequences, random vs model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_quad_decoder_mc;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int FILT   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  enc_a, enc_b, cnt_clr, err_clr;
    logic        snap;
    logic [31:0] count_o, snap_o;
    logic [1:0]  dir_o, step_o, err_o;

    quad_decoder_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FILT_LEN(FILT), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .cnt_clr(cnt_clr),
        .snap(snap), .err_clr(err_clr), .count_o(count_o), .snap_o(snap_o),
        .dir_o(dir_o), .step_o(step_o), .err_o(err_o)
    );

    // Fast-filter instance used to reach the counter wrap boundary quickly
    logic        reset2, a2, b2, clr2, snap2, eclr2;
    logic [15:0] count2, snapv2;
    logic        dir2, step2, err2;

    quad_decoder_mc #(.NUM_CH(1), .CNT_W(16), .FILT_LEN(1), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset(reset2), .enc_a(a2), .enc_b(b2), .cnt_clr(clr2),
        .snap(snap2), .err_clr(eclr2), .count_o(count2), .snap_o(snapv2),
        .dir_o(dir2), .step_o(step2), .err_o(err2)
    );

    int nvec = 0;
    int nerr = 0;

    int step_seen [2] = '{0, 0};
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) if (step_o[c] === 1'b1) step_seen[c]++;
    end

    // Reference model: position tracked as index around the Gray cycle
    logic [15:0] mcount [2];
    logic        mdir   [2];
    logic        merr   [2];
    logic [1:0]  mstate [2];
    int          msteps [2];
    int          sbase  [2];
    logic [31:0] msnap;

    function automatic int gpos(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gstate(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_apply(input int ch, input logic [1:0] ns);
        int d;
        d = (gpos(ns) - gpos(mstate[ch]) + 4) % 4;
        if (d == 1) begin
            mcount[ch] = mcount[ch] + 16'd1; mdir[ch] = 1'b0; msteps[ch]++;
        end else if (d == 3) begin
            mcount[ch] = mcount[ch] - 16'd1; mdir[ch] = 1'b1; msteps[ch]++;
        end else if (d == 2) begin
            merr[ch] = 1'b1;
        end
        mstate[ch] = ns;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_state(input int ch, input logic [1:0] s);
        enc_b[ch] = s[1];
        enc_a[ch] = s[0];
    endtask

    task automatic check_all(input string tag);
        chk({tag, " count0"}, {16'h0, count_o[15:0]},  {16'h0, mcount[0]});
        chk({tag, " count1"}, {16'h0, count_o[31:16]}, {16'h0, mcount[1]});
        chk({tag, " dir"},    {30'h0, dir_o},          {30'h0, mdir[1], mdir[0]});
        chk({tag, " err"},    {30'h0, err_o},          {30'h0, merr[1], merr[0]});
        chk({tag, " snap"},   snap_o,                  msnap);
        chk({tag, " steps0"}, 32'(step_seen[0] - sbase[0]), 32'(msteps[0]));
        chk({tag, " steps1"}, 32'(step_seen[1] - sbase[1]), 32'(msteps[1]));
    endtask

    task automatic do_reset(input logic [1:0] s0, input logic [1:0] s1);
        reset = 1'b1; cnt_clr = '0; err_clr = '0; snap = 1'b0;
        set_state(0, s0);
        set_state(1, s1);
        tick(1);
        sbase[0] = step_seen[0];
        sbase[1] = step_seen[1];
        tick(3);
        reset = 1'b0;
        tick(25);
        for (int c = 0; c < 2; c++) begin
            mcount[c] = '0; mdir[c] = 1'b0; merr[c] = 1'b0; msteps[c] = 0;
        end
        mstate[0] = s0;
        mstate[1] = s1;
        msnap = '0;
    endtask

    typedef struct packed {
        logic [1:0]  s0;
        logic [1:0]  s1;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [1:0]  dir;
        logic [1:0]  err;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int lat;
        int r;
        int ch;
        int len;
        logic [1:0] m;

        tbl[0] = '{2'b00, 2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00};
        tbl[1] = '{2'b01, 2'b10, 16'h0001, 16'hFFFF, 2'b10, 2'b00};
        tbl[2] = '{2'b11, 2'b11, 16'h0002, 16'hFFFE, 2'b10, 2'b00};
        tbl[3] = '{2'b10, 2'b01, 16'h0003, 16'hFFFD, 2'b10, 2'b00};
        tbl[4] = '{2'b11, 2'b01, 16'h0002, 16'hFFFD, 2'b11, 2'b00};
        tbl[5] = '{2'b00, 2'b01, 16'h0002, 16'hFFFD, 2'b11, 2'b01};
        tbl[6] = '{2'b00, 2'b00, 16'h0002, 16'hFFFC, 2'b11, 2'b01};
        tbl[7] = '{2'b01, 2'b10, 16'h0003, 16'hFFFB, 2'b10, 2'b01};
        tbl[8] = '{2'b10, 2'b01, 16'h0003, 16'hFFFB, 2'b10, 2'b11};

        reset = 1'b1; enc_a = '0; enc_b = '0; cnt_clr = '0; err_clr = '0; snap = 1'b0;
        reset2 = 1'b1; a2 = 1'b0; b2 = 1'b0; clr2 = 1'b0; snap2 = 1'b0; eclr2 = 1'b0;

        // Reset state
        tick(3);
        chk("reset count", count_o, 32'h0);
        chk("reset snap",  snap_o,  32'h0);
        chk("reset dir",   {30'h0, dir_o},  32'h0);
        chk("reset step",  {30'h0, step_o}, 32'h0);
        chk("reset err",   {30'h0, err_o},  32'h0);
        reset = 1'b0;
        tick(20);

        // Vector table, each row held long enough for the full pipeline
        for (int i = 0; i < 9; i++) begin
            set_state(0, tbl[i].s0);
            set_state(1, tbl[i].s1);
            tick(10);
            chk($sformatf("row%0d count0", i), {16'h0, count_o[15:0]},  {16'h0, tbl[i].c0});
            chk($sformatf("row%0d count1", i), {16'h0, count_o[31:16]}, {16'h0, tbl[i].c1});
            chk($sformatf("row%0d dir", i),    {30'h0, dir_o}, {30'h0, tbl[i].dir});
            chk($sformatf("row%0d err", i),    {30'h0, err_o}, {30'h0, tbl[i].err});
        end

        // Error clear, then clear colliding with an illegal jump
        err_clr = 2'b11; tick(1); err_clr = 2'b00;
        chk("err_clr both", {30'h0, err_o}, 32'h0);
        set_state(0, 2'b01);
        tick(6);
        err_clr = 2'b01; tick(1); err_clr = 2'b00;
        chk("err_clr vs illegal", {31'h0, err_o[0]}, 32'h1);
        chk("illegal count0", {16'h0, count_o[15:0]}, 32'h3);
        err_clr = 2'b01; tick(1); err_clr = 2'b00;
        chk("err_clr again", {31'h0, err_o[0]}, 32'h0);

        // Snapshot, then reset mid-operation overriding other inputs
        snap = 1'b1; tick(1); snap = 1'b0;
        chk("snap values", snap_o, 32'hFFFB_0003);
        tick(3);
        chk("snap holds", snap_o, 32'hFFFB_0003);
        reset = 1'b1; snap = 1'b1; cnt_clr = 2'b11;
        tick(1);
        chk("midreset count", count_o, 32'h0);
        chk("midreset snap",  snap_o,  32'h0);
        chk("midreset dir",   {30'h0, dir_o}, 32'h0);
        snap = 1'b0; cnt_clr = 2'b00;

        // Pins held at 11 through reset: first accepted state is silent
        do_reset(2'b11, 2'b11);
        check_all("pins11 reset");
        tick(20);
        check_all("pins11 later");

        // Latency from pin edge to count change, and filter glitch rejection
        do_reset(2'b00, 2'b00);
        set_state(1, 2'b10);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (lat == 0 && count_o[31:16] != 16'h0) lat = k;
        end
        chk("latency", 32'(lat), 32'd7);
        model_apply(1, 2'b10);
        check_all("latency");
        enc_a[0] = 1'b1; tick(FILT - 1); enc_a[0] = 1'b0;
        tick(15);
        check_all("glitch3");
        enc_a[0] = 1'b1; model_apply(0, 2'b01);
        tick(15);
        check_all("stable4");
        chk("stable4 one count", {16'h0, count_o[15:0]}, 32'h1);

        // Eight forward cycles on ch0, 16 clocks per phase
        do_reset(2'b00, 2'b00);
        for (int p = 1; p <= 32; p++) begin
            set_state(0, gstate(p));
            model_apply(0, gstate(p));
            tick(16);
        end
        check_all("fwd8");
        chk("fwd8 count0", {16'h0, count_o[15:0]}, 32'd32);
        chk("fwd8 steps0", 32'(step_seen[0] - sbase[0]), 32'd32);

        // Randomised segments against the model
        do_reset(2'b00, 2'b00);
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                for (int c = 0; c < 2; c++) begin
                    m = 2'($urandom_range(0, 3));
                    set_state(c, m);
                    model_apply(c, m);
                end
                tick($urandom_range(9, 14));
            end else if (r == 6) begin
                ch  = $urandom_range(0, 1);
                len = $urandom_range(1, FILT - 1);
                if ($urandom_range(0, 1) == 0) begin
                    enc_a[ch] = ~enc_a[ch]; tick(len); enc_a[ch] = ~enc_a[ch];
                end else begin
                    enc_b[ch] = ~enc_b[ch]; tick(len); enc_b[ch] = ~enc_b[ch];
                end
                tick(12);
            end else if (r == 7) begin
                m = 2'($urandom_range(1, 3));
                cnt_clr = m; tick(1); cnt_clr = 2'b00;
                for (int c = 0; c < 2; c++) if (m[c]) mcount[c] = '0;
                tick(2);
            end else if (r == 8) begin
                m = 2'($urandom_range(1, 3));
                err_clr = m; tick(1); err_clr = 2'b00;
                for (int c = 0; c < 2; c++) if (m[c]) merr[c] = 1'b0;
                tick(2);
            end else begin
                msnap = {mcount[1], mcount[0]};
                snap = 1'b1; tick(1); snap = 1'b0;
                tick(2);
            end
            check_all($sformatf("rand%0d", s));
        end

        // Wrap at the signed boundary, then clear+snap colliding with a step
        reset2 = 1'b1; tick(3); reset2 = 1'b0; tick(10);
        for (int k = 1; k <= 32767; k++) begin
            {b2, a2} = gstate(k);
            tick(1);
        end
        tick(10);
        chk("wrap pre", {16'h0, count2}, 32'h7FFF);
        {b2, a2} = gstate(32768);
        tick(8);
        chk("wrap 7FFF+1", {16'h0, count2}, 32'h8000);
        chk("wrap dir", {31'h0, dir2}, 32'h0);
        {b2, a2} = gstate(32769);
        tick(3);
        clr2 = 1'b1; snap2 = 1'b1;
        tick(1);
        clr2 = 1'b0; snap2 = 1'b0;
        chk("clr wins count", {16'h0, count2}, 32'h0);
        chk("snap pre-clear", {16'h0, snapv2}, 32'h8000);
        chk("clr step pulse", {31'h0, step2}, 32'h1);
        chk("clr dir", {31'h0, dir2}, 32'h0);
        tick(5);
        chk("snap2 holds", {16'h0, snapv2}, 32'h8000);
        chk("dut2 err", {31'h0, err2}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
